// File: rtl/drive_guard.sv
// drive_guard: per-computer debounced overheat shut-off plus a registered trip FSM.
// Optional build macro DRIVE_GUARD_STICKY_EN: shut-offs latch until reset; all-shut aborts DRIVE.
module drive_guard #(
  parameter int N_CPU       = 4,
  parameter int FUEL_W      = 8,
  parameter int FUEL_LOW    = 16,
  parameter int HOT_CYCLES  = 3,
  parameter int COOL_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CPU-1:0]  cpu_overheated,
  input  logic              start,
  input  logic              arrived,
  input  logic [FUEL_W-1:0] fuel_level,
  output logic [N_CPU-1:0]  shut_off_computer,
  output logic              keep_driving,
  output logic              low_fuel,
  output logic [1:0]        trip_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    ARRIVED = 2'd2,
    EMPTY   = 2'd3
  } trip_e;

  localparam int              HW         = $clog2(HOT_CYCLES + 1);
  localparam logic [HW-1:0]   HOT_LAST   = HW'(HOT_CYCLES - 1);
  localparam logic [FUEL_W-1:0] FUEL_LOW_V = FUEL_W'(FUEL_LOW);

  logic [HW-1:0]    hot_cnt_q [N_CPU];
  logic [HW-1:0]    hot_cnt_d [N_CPU];
  logic [N_CPU-1:0] shut_q, shut_d;
  trip_e            state_q, state_d;
  logic             keep_q, low_q;

`ifndef DRIVE_GUARD_STICKY_EN
  localparam int            CW        = $clog2(COOL_CYCLES + 1);
  localparam logic [CW-1:0] COOL_LAST = CW'(COOL_CYCLES - 1);

  logic [CW-1:0] cool_cnt_q [N_CPU];
  logic [CW-1:0] cool_cnt_d [N_CPU];
`endif

  // Counters clear on the qualifying edge, so they never exceed their last value.
  always_comb begin
    shut_d    = shut_q;
    hot_cnt_d = hot_cnt_q;
`ifndef DRIVE_GUARD_STICKY_EN
    cool_cnt_d = cool_cnt_q;
`endif
    for (int i = 0; i < N_CPU; i++) begin
      if (!shut_q[i]) begin
        if (cpu_overheated[i]) begin
          if (hot_cnt_q[i] == HOT_LAST) begin
            shut_d[i]    = 1'b1;
            hot_cnt_d[i] = '0;
          end else begin
            hot_cnt_d[i] = hot_cnt_q[i] + 1'b1;
          end
        end else begin
          hot_cnt_d[i] = '0;
        end
      end
`ifndef DRIVE_GUARD_STICKY_EN
      else if (!cpu_overheated[i]) begin
        if (cool_cnt_q[i] == COOL_LAST) begin
          shut_d[i]     = 1'b0;
          cool_cnt_d[i] = '0;
        end else begin
          cool_cnt_d[i] = cool_cnt_q[i] + 1'b1;
        end
      end else begin
        cool_cnt_d[i] = '0;
      end
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start && (fuel_level != '0) && !arrived) state_d = DRIVE;
      end
      DRIVE: begin
        if (arrived)                 state_d = ARRIVED;
        else if (fuel_level == '0)   state_d = EMPTY;
`ifdef DRIVE_GUARD_STICKY_EN
        else if (&shut_q)            state_d = IDLE;
`endif
      end
      ARRIVED: begin
        if (!arrived && start) state_d = (fuel_level != '0) ? DRIVE : EMPTY;
      end
      EMPTY: begin
        if (fuel_level >= FUEL_LOW_V) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shut_q  <= '0;
      state_q <= IDLE;
      keep_q  <= 1'b0;
      low_q   <= 1'b0;
      for (int i = 0; i < N_CPU; i++) begin
        hot_cnt_q[i] <= '0;
`ifndef DRIVE_GUARD_STICKY_EN
        cool_cnt_q[i] <= '0;
`endif
      end
    end else begin
      shut_q  <= shut_d;
      state_q <= state_d;
      keep_q  <= (state_d == DRIVE);
      low_q   <= (fuel_level < FUEL_LOW_V);
      for (int i = 0; i < N_CPU; i++) begin
        hot_cnt_q[i] <= hot_cnt_d[i];
`ifndef DRIVE_GUARD_STICKY_EN
        cool_cnt_q[i] <= cool_cnt_d[i];
`endif
      end
    end
  end

  assign shut_off_computer = shut_q;
  assign keep_driving      = keep_q;
  assign low_fuel          = low_q;
  assign trip_state        = state_q;

endmodule

// File: tb/tb_drive_guard.sv
// Directed plus randomized bench for drive_guard against a run-length reference model.
module tb_drive_guard;

  localparam int N    = 4;
  localparam int FW   = 8;
  localparam int FLOW = 16;
  localparam int HOT  = 3;
  localparam int COOL = 8;
  localparam int S_IDLE = 0, S_DRIVE = 1, S_ARR = 2, S_EMPTY = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  cpu_overheated;
  logic          start, arrived;
  logic [FW-1:0] fuel_level;
  logic [N-1:0]  shut_off_computer;
  logic          keep_driving, low_fuel;
  logic [1:0]    trip_state;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int           hot_run  [N];
  int           cool_run [N];
  logic [N-1:0] m_shut;
  int           m_state;
  logic         m_keep, m_low;

  drive_guard #(
    .N_CPU(N), .FUEL_W(FW), .FUEL_LOW(FLOW), .HOT_CYCLES(HOT), .COOL_CYCLES(COOL)
  ) dut (
    .clk(clk), .reset(reset), .cpu_overheated(cpu_overheated), .start(start),
    .arrived(arrived), .fuel_level(fuel_level), .shut_off_computer(shut_off_computer),
    .keep_driving(keep_driving), .low_fuel(low_fuel), .trip_state(trip_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit all_shut;
    int nxt;
    all_shut = (m_shut == {N{1'b1}});
    if (reset) begin
      for (int i = 0; i < N; i++) begin hot_run[i] = 0; cool_run[i] = 0; end
      m_shut = '0; m_state = S_IDLE; m_keep = 0; m_low = 0;
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (!m_shut[i]) begin
        hot_run[i] = cpu_overheated[i] ? hot_run[i] + 1 : 0;
        if (hot_run[i] == HOT) begin m_shut[i] = 1'b1; hot_run[i] = 0; end
      end else begin
`ifndef DRIVE_GUARD_STICKY_EN
        cool_run[i] = cpu_overheated[i] ? 0 : cool_run[i] + 1;
        if (cool_run[i] == COOL) begin m_shut[i] = 1'b0; cool_run[i] = 0; end
`endif
      end
    end
    nxt = m_state;
    case (m_state)
      S_IDLE:  if (start && fuel_level != 0 && !arrived) nxt = S_DRIVE;
      S_DRIVE: begin
        if (arrived) nxt = S_ARR;
        else if (fuel_level == 0) nxt = S_EMPTY;
`ifdef DRIVE_GUARD_STICKY_EN
        else if (all_shut) nxt = S_IDLE;
`endif
      end
      S_ARR:   if (!arrived && start) nxt = (fuel_level != 0) ? S_DRIVE : S_EMPTY;
      default: if (int'(fuel_level) >= FLOW) nxt = S_IDLE;
    endcase
    m_state = nxt;
    m_keep  = (nxt == S_DRIVE);
    m_low   = (int'(fuel_level) < FLOW);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("shut_off_computer", 32'(shut_off_computer), 32'(m_shut));
    chk("trip_state", 32'(trip_state), 32'(m_state));
    chk("keep_driving", 32'(keep_driving), 32'(m_keep));
    chk("low_fuel", 32'(low_fuel), 32'(m_low));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    m_shut = '0; m_state = S_IDLE; m_keep = 0; m_low = 0;
    for (int i = 0; i < N; i++) begin hot_run[i] = 0; cool_run[i] = 0; end

    // Reset with random inputs
    reset = 1'b1;
    cpu_overheated = N'($urandom); start = 1'($urandom);
    arrived = 1'($urandom); fuel_level = FW'($urandom);
    #2;
    tick();
    chk("reset_shut", 32'(shut_off_computer), 32'h0);
    chk("reset_state", 32'(trip_state), 32'h0);
    cpu_overheated = N'($urandom); start = 1'($urandom); fuel_level = FW'($urandom);
    tick();

    reset = 1'b0; cpu_overheated = '0; start = 0; arrived = 0; fuel_level = 8'd100;
    ticks(2);

    // ch0 debounce: 2 high, 1 low, 3 high
    cpu_overheated = 4'b0001; ticks(2);
    cpu_overheated = 4'b0000; tick();
    cpu_overheated = 4'b0001; ticks(2);
    chk("ch0_not_yet", 32'(shut_off_computer), 32'h0);
    tick();
    chk("ch0_shut", 32'(shut_off_computer), 32'h1);

    // ch1 shut, then interrupted cool-down
    cpu_overheated = 4'b0010; ticks(3);
    chk("ch1_shut", 32'(shut_off_computer[1]), 32'h1);
    cpu_overheated = 4'b0000; ticks(7);
    chk("ch1_cool7", 32'(shut_off_computer[1]), 32'h1);
    cpu_overheated = 4'b0010; tick();
    cpu_overheated = 4'b0000; ticks(7);
    chk("ch1_cool7b", 32'(shut_off_computer), 32'h2);
    tick();
    chk("ch1_cleared", 32'(shut_off_computer), 32'h0);

    // Trip: start, then arrival with simultaneous empty
    fuel_level = 8'd100; start = 1; tick();
    chk("start_keep", 32'(keep_driving), 32'h1);
    start = 0; tick();
    fuel_level = 8'd0; arrived = 1; tick();
    chk("arrive_state", 32'(trip_state), 32'(S_ARR));
    chk("arrive_keep", 32'(keep_driving), 32'h0);
    arrived = 0; fuel_level = 8'd100; start = 1; tick();
    start = 0; fuel_level = 8'd0; tick();
    chk("empty_state", 32'(trip_state), 32'(S_EMPTY));
    fuel_level = 8'd10; tick();
    chk("topup_state", 32'(trip_state), 32'(S_EMPTY));
    chk("topup_low", 32'(low_fuel), 32'h1);
    fuel_level = 8'd16; tick();
    chk("refuel_state", 32'(trip_state), 32'(S_IDLE));
    chk("refuel_low", 32'(low_fuel), 32'h0);
    start = 1; tick();
    chk("restart_state", 32'(trip_state), 32'(S_DRIVE));
    start = 0;

`ifdef DRIVE_GUARD_STICKY_EN
    cpu_overheated = 4'hF; ticks(3);
    chk("sticky_allshut", 32'(shut_off_computer), 32'hF);
    chk("sticky_still_drive", 32'(trip_state), 32'(S_DRIVE));
    cpu_overheated = 4'h0; tick();
    chk("sticky_abort", 32'(trip_state), 32'(S_IDLE));
    ticks(19);
    chk("sticky_hold", 32'(shut_off_computer), 32'hF);
    reset = 1; tick();
    chk("sticky_reset", 32'(shut_off_computer), 32'h0);
    reset = 0;
`endif

    // Randomized phase: sticky-ish flag runs, biased fuel values
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(3) == 0) cpu_overheated[i] = ~cpu_overheated[i];
      start   = ($urandom_range(3) == 0);
      arrived = ($urandom_range(5) == 0);
      case ($urandom_range(5))
        0: fuel_level = 8'd0;
        1: fuel_level = 8'd15;
        2: fuel_level = 8'd16;
        default: fuel_level = FW'($urandom);
      endcase
      reset = ($urandom_range(99) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
